mod_field_counter: RTL and testbench
====================================

// Module: mod_field_counter
// PURPOSE
//  Generic time-field counter (sec/min/hour/day): counts 0..P_MODULUS-1 on qualified tics, up or down.
//  Provides zero-latency carry/borrow for chaining to the next field, synchronous load, and +/-1 adjust.
//  Keeps a BCD (tens/ones) copy in lock-step for direct display drive.
//  Replaces the fixed-modulo-60 minute generator; chained instances form the clock/timer datapath.
// PARAMETERS
//  P_WIDTH    6   binary value width; 2**P_WIDTH >= P_MODULUS
//  P_MODULUS  60  count modulus, 2..100 (BCD copy limited to two digits)
//  P_INIT     0   value loaded on reset, 0..P_MODULUS-1
// PORTS
//  clk       in   1        clock
//  reset     in   1        synchronous, active-high
//  en        in   1        run enable; gates tic_in only
//  tic_in    in   1        1-cycle count request (carry of lower field)
//  dir       in   1        0 = count up, 1 = count down
//  load      in   1        1-cycle load strobe
//  load_val  in   P_WIDTH  value to load
//  adj_up    in   1        1-cycle +1 adjust (set mode)
//  adj_dn    in   1        1-cycle -1 adjust (set mode)
//  value     out  P_WIDTH  binary count, registered
//  bcd_tens  out  4        BCD tens digit of value, registered
//  bcd_ones  out  4        BCD ones digit of value, registered
//  carry_out out  1        combinational: this tic wraps the field (to next field's tic_in)
//  at_max    out  1        combinational level: value == P_MODULUS-1
//  load_err  out  1        registered 1-cycle pulse: rejected load
// BEHAVIOUR
//  Reset: value=P_INIT, bcd_tens/bcd_ones = BCD(P_INIT), load_err=0; reset overrides all inputs.
//  Per-cycle priority, one action per cycle: reset > load > adjust > tic.
//  load: if load_val < P_MODULUS -> value=load_val next cycle, BCD matches same cycle.
//    load_val >= P_MODULUS -> value unchanged, load_err=1 for one cycle. load ignores en.
//  adjust: adj_up xor adj_dn -> +1/-1 with wrap (MOD-1 -> 0, 0 -> MOD-1); both high -> no change.
//    adjust ignores en and dir, never asserts carry_out.
//  tic: count when en & tic_in & no load & no adjust; dir=0: +1, MOD-1 wraps to 0; dir=1: -1, 0 wraps to MOD-1.
//    tic arriving with load or adjust is dropped (not queued).
//  carry_out = en & tic_in & ~load & ~(adj_up|adj_dn) & (dir ? value==0 : value==MOD-1).
//    Same cycle as the wrapping tic (zero latency) so the next field steps on the same edge.
//  at_max: level, independent of en/dir (legacy hour_tic-style output).
//  Latency: value/BCD update on the edge after the qualifying strobe; no internal pipeline.
//  BCD: separate digit counters updated alongside value (no divider); ones 9->0 bumps tens; wrap to
//    BCD(0) or BCD(MOD-1) at modulus; load/reset compute digits from the binary value.
//    Invariant every cycle: 10*bcd_tens + bcd_ones == value.
//  Arithmetic: all compares on P_WIDTH bits; value never leaves 0..P_MODULUS-1.
//  Mid-operation reset: next edge restores P_INIT; carry_out is 0 while reset is high.
//  dir change takes effect on the next tic; no state is held for it.
// TESTING
//  1 Reset, en=1, dir=0, 60 tics -> value 0..59 then 0, carry_out high only on the tic at 59, BCD tracks.
//  2 dir=1 from value=0, one tic -> value=59, BCD 5/9, carry_out=1 that cycle; next tic -> 58, carry_out=0.
//  3 load_val=37 -> value=37, BCD 3/7; load_val=60 -> value held, load_err 1 cycle; load+tic same cycle -> load wins, no carry.
//  4 value=59, adj_up -> 0 with carry_out=0; adj_dn -> 59; adj_up+adj_dn -> unchanged; en=0 + tic -> no change.
//  5 Chain P_MODULUS=60 and P_MODULUS=24 instances, start 23:59, one tic -> 00:00 on same edge, both carries seen.
//  6 Reset asserted mid-count at value=42 with tic -> next value=P_INIT, carry_out=0; scoreboard checks BCD invariant every cycle.

Source files
------------

// File: rtl/mod_field_counter_if.sv
// Control/status bundle for one time-field counter; the master drives strobes and the slave reports count state.
interface mod_field_counter_if #(
    parameter int P_WIDTH = 6
);
    logic               en;
    logic               tic_in;
    logic               dir;
    logic               load;
    logic [P_WIDTH-1:0] load_val;
    logic               adj_up;
    logic               adj_dn;
    logic [P_WIDTH-1:0] value;
    logic [3:0]         bcd_tens;
    logic [3:0]         bcd_ones;
    logic               carry_out;
    logic               at_max;
    logic               load_err;

    modport master (
        output en, tic_in, dir, load, load_val, adj_up, adj_dn,
        input  value, bcd_tens, bcd_ones, carry_out, at_max, load_err
    );

    modport slave (
        input  en, tic_in, dir, load, load_val, adj_up, adj_dn,
        output value, bcd_tens, bcd_ones, carry_out, at_max, load_err
    );
endinterface

// File: rtl/mod_field_counter.sv
// Modulo-N time-field counter (up/down, load, adjust) with a lock-step two-digit BCD copy
// and a zero-latency carry/borrow for chaining fields.
module mod_field_counter #(
    parameter int P_WIDTH   = 6,
    parameter int P_MODULUS = 60,
    parameter int P_INIT    = 0
) (
    input  logic               clk,
    input  logic               reset,
    mod_field_counter_if.slave bus
);
    localparam logic [P_WIDTH-1:0] MAX_V  = P_WIDTH'(P_MODULUS - 1);
    localparam logic [P_WIDTH-1:0] INIT_V = P_WIDTH'(P_INIT);
    localparam logic [3:0]         MAX_T  = 4'((P_MODULUS - 1) / 10);
    localparam logic [3:0]         MAX_O  = 4'((P_MODULUS - 1) % 10);
    localparam logic [3:0]         INIT_T = 4'(P_INIT / 10);
    localparam logic [3:0]         INIT_O = 4'(P_INIT % 10);

    // Digits are only derived from binary on load; counting steps the digit counters directly.
    function automatic logic [7:0] to_bcd(input logic [P_WIDTH-1:0] v);
        int i;
        i = int'(v);
        return {4'(i / 10), 4'(i % 10)};
    endfunction

    logic [P_WIDTH-1:0] value_q, value_d;
    logic [3:0]         tens_q, tens_d;
    logic [3:0]         ones_q, ones_d;
    logic               load_err_q, load_err_d;

    logic       adj_one, tic, is_max, is_zero, load_ok, step_up, step_dn;
    logic [7:0] bcd_ld;

    always_comb begin
        adj_one = bus.adj_up ^ bus.adj_dn;
        tic     = bus.en & bus.tic_in & ~bus.load & ~(bus.adj_up | bus.adj_dn);
        is_max  = (value_q == MAX_V);
        is_zero = (value_q == '0);
        // One extra bit so a modulus of exactly 2**P_WIDTH still compares correctly.
        load_ok = ({1'b0, bus.load_val} < (P_WIDTH + 1)'(P_MODULUS));
        step_up = ~bus.load & ((adj_one & bus.adj_up) | (tic & ~bus.dir));
        step_dn = ~bus.load & ((adj_one & bus.adj_dn) | (tic & bus.dir));
        bcd_ld  = to_bcd(bus.load_val);

        value_d    = value_q;
        tens_d     = tens_q;
        ones_d     = ones_q;
        load_err_d = 1'b0;

        if (bus.load) begin
            if (load_ok) begin
                value_d = bus.load_val;
                tens_d  = bcd_ld[7:4];
                ones_d  = bcd_ld[3:0];
            end else begin
                load_err_d = 1'b1;
            end
        end else if (step_up) begin
            if (is_max) begin
                value_d = '0;
                tens_d  = 4'd0;
                ones_d  = 4'd0;
            end else begin
                value_d = value_q + 1'b1;
                if (ones_q == 4'd9) begin
                    ones_d = 4'd0;
                    tens_d = tens_q + 4'd1;
                end else begin
                    ones_d = ones_q + 4'd1;
                end
            end
        end else if (step_dn) begin
            if (is_zero) begin
                value_d = MAX_V;
                tens_d  = MAX_T;
                ones_d  = MAX_O;
            end else begin
                value_d = value_q - 1'b1;
                if (ones_q == 4'd0) begin
                    ones_d = 4'd9;
                    tens_d = tens_q - 4'd1;
                end else begin
                    ones_d = ones_q - 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            value_q    <= INIT_V;
            tens_q     <= INIT_T;
            ones_q     <= INIT_O;
            load_err_q <= 1'b0;
        end else begin
            value_q    <= value_d;
            tens_q     <= tens_d;
            ones_q     <= ones_d;
            load_err_q <= load_err_d;
        end
    end

    // Carry is combinational so the next field steps on the same edge as the wrap.
    assign bus.carry_out = ~reset & tic & (bus.dir ? is_zero : is_max);
    assign bus.at_max    = is_max;
    assign bus.value     = value_q;
    assign bus.bcd_tens  = tens_q;
    assign bus.bcd_ones  = ones_q;
    assign bus.load_err  = load_err_q;
endmodule

// File: tb/tb_mod_field_counter.sv
// Minute (mod 60) and hour (mod 24) counters chained through carry_out, checked against a
// behavioural model via an expected-result queue.
module tb_mod_field_counter;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mod_field_counter_if #(.P_WIDTH(6)) m_if ();
    mod_field_counter_if #(.P_WIDTH(5)) h_if ();

    mod_field_counter #(.P_WIDTH(6), .P_MODULUS(60), .P_INIT(0)) u_min (
        .clk(clk), .reset(reset), .bus(m_if.slave));
    mod_field_counter #(.P_WIDTH(5), .P_MODULUS(24), .P_INIT(0)) u_hr (
        .clk(clk), .reset(reset), .bus(h_if.slave));

    assign h_if.tic_in = m_if.carry_out;
    assign h_if.dir    = m_if.dir;
    assign h_if.en     = 1'b1;

    typedef struct {
        int mv;
        bit me;
        int hv;
        bit he;
    } exp_t;
    exp_t sb_q[$];

    int n_chk  = 0;
    int n_fail = 0;
    int m_val  = 0;
    int h_val  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int nxt(input int cur, input int md, input bit rst, input bit en,
                               input bit tic, input bit dir, input bit ld, input int lv,
                               input bit au, input bit ad, output bit cy, output bit err);
        cy  = 1'b0;
        err = 1'b0;
        if (rst) return 0;
        if (ld) begin
            if (lv < md) return lv;
            err = 1'b1;
            return cur;
        end
        if (au && !ad) return (cur == md - 1) ? 0 : cur + 1;
        if (ad && !au) return (cur == 0) ? md - 1 : cur - 1;
        if (au && ad) return cur;
        if (en && tic) begin
            cy = dir ? (cur == 0) : (cur == md - 1);
            if (dir) return (cur == 0) ? md - 1 : cur - 1;
            return (cur == md - 1) ? 0 : cur + 1;
        end
        return cur;
    endfunction

    task automatic step(input bit rst, input bit en, input bit tic, input bit dir,
                        input bit ld, input int lv, input bit au, input bit ad,
                        input bit hld = 1'b0, input int hlv = 0);
        int    mn, hn;
        bit    mcy, merr, hcy, herr;
        exp_t  e;
        logic [31:0] lvv, hlvv;
        lvv  = lv;
        hlvv = hlv;
        @(negedge clk);
        reset         = rst;
        m_if.en       = en;
        m_if.tic_in   = tic;
        m_if.dir      = dir;
        m_if.load     = ld;
        m_if.load_val = lvv[5:0];
        m_if.adj_up   = au;
        m_if.adj_dn   = ad;
        h_if.load     = hld;
        h_if.load_val = hlvv[4:0];
        h_if.adj_up   = 1'b0;
        h_if.adj_dn   = 1'b0;
        #1;
        mn = nxt(m_val, 60, rst, en, tic, dir, ld, lv, au, ad, mcy, merr);
        hn = nxt(h_val, 24, rst, 1'b1, mcy, dir, hld, hlv, 1'b0, 1'b0, hcy, herr);
        chk("m_carry", 32'(m_if.carry_out), 32'(mcy));
        chk("m_at_max", 32'(m_if.at_max), 32'(m_val == 59));
        chk("h_carry", 32'(h_if.carry_out), 32'(hcy));
        chk("h_at_max", 32'(h_if.at_max), 32'(h_val == 23));
        sb_q.push_back('{mv: mn, me: merr, hv: hn, he: herr});
        m_val = mn;
        h_val = hn;
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        chk("m_value", 32'(m_if.value), e.mv);
        chk("m_tens", 32'(m_if.bcd_tens), e.mv / 10);
        chk("m_ones", 32'(m_if.bcd_ones), e.mv % 10);
        chk("m_load_err", 32'(m_if.load_err), 32'(e.me));
        chk("m_bcd_inv", 10 * int'(m_if.bcd_tens) + int'(m_if.bcd_ones), 32'(m_if.value));
        chk("h_value", 32'(h_if.value), e.hv);
        chk("h_tens", 32'(h_if.bcd_tens), e.hv / 10);
        chk("h_ones", 32'(h_if.bcd_ones), e.hv % 10);
        chk("h_load_err", 32'(h_if.load_err), 32'(e.he));
        chk("h_bcd_inv", 10 * int'(h_if.bcd_tens) + int'(h_if.bcd_ones), 32'(h_if.value));
    endtask

    initial begin
        reset = 1'b1;
        m_if.en = 1'b0; m_if.tic_in = 1'b0; m_if.dir = 1'b0; m_if.load = 1'b0;
        m_if.load_val = '0; m_if.adj_up = 1'b0; m_if.adj_dn = 1'b0;
        h_if.load = 1'b0; h_if.load_val = '0; h_if.adj_up = 1'b0; h_if.adj_dn = 1'b0;

        // reset state
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 1, 0, 0, 0, 0, 0);

        // 60 up tics: full wrap, hour steps once
        for (int i = 0; i < 60; i++) step(0, 1, 1, 0, 0, 0, 0, 0);
        chk("wrap_value", 32'(m_if.value), 0);
        chk("hour_after_wrap", 32'(h_if.value), 1);

        // down from 0: borrow, then plain decrement
        step(0, 1, 1, 1, 0, 0, 0, 0);
        step(0, 1, 1, 1, 0, 0, 0, 0);
        chk("down_58", 32'(m_if.value), 58);

        // load good / bad / load beats tic
        step(0, 1, 0, 0, 1, 37, 0, 0);
        step(0, 1, 0, 0, 1, 60, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0);
        step(0, 1, 1, 0, 1, 59, 0, 0);
        step(0, 1, 1, 0, 1, 63, 0, 0);

        // adjust at the wrap point, with a tic that must be dropped
        step(0, 1, 1, 0, 0, 0, 1, 0);
        step(0, 1, 1, 1, 0, 0, 0, 1);
        step(0, 1, 1, 0, 0, 0, 1, 1);
        step(0, 0, 1, 0, 0, 0, 0, 0);
        step(0, 0, 1, 1, 0, 0, 1, 0);

        // chained 23:59 -> 00:00
        step(0, 1, 0, 0, 1, 59, 0, 0, 1, 23);
        step(0, 1, 1, 0, 0, 0, 0, 0);
        chk("chain_min", 32'(m_if.value), 0);
        chk("chain_hr", 32'(h_if.value), 0);
        // chained 00:00 -> 23:59 downward
        step(0, 1, 1, 1, 0, 0, 0, 0);

        // reset mid-count with a tic pending
        step(0, 1, 0, 0, 1, 41, 0, 0);
        step(0, 1, 1, 0, 0, 0, 0, 0);
        step(1, 1, 1, 0, 0, 0, 0, 0);
        step(1, 1, 1, 1, 0, 0, 0, 0);

        // random mix
        for (int i = 0; i < 200; i++) begin
            step(($urandom_range(0, 40) == 0), ($urandom_range(0, 3) != 0), $urandom_range(0, 1),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0), $urandom_range(0, 63),
                 ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 19) == 0), $urandom_range(0, 31));
        end

        chk("sb_empty", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
